// File: rtl/key_bounce_gen.sv
// Bouncy active-low key generator: turns a one-cycle press request into a
// press/hold/release waveform with LFSR-timed glitches on both edges.
module key_bounce_gen #(
    parameter int unsigned N_BOUNCE = 3,
    parameter int unsigned GLITCH_W = 2,
    parameter int unsigned HOLD_CYC = 20,
    parameter int unsigned CNT_W    = 16,
    parameter logic [7:0]  SEED     = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             press_req,
    input  logic [CNT_W-1:0] hold_len,
    output logic             key,
    output logic             busy,
    output logic             done,
    output logic [7:0]       edge_cnt
);

    localparam int unsigned N_SEG     = 2 * N_BOUNCE;
    localparam int unsigned SEG_IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;
    localparam logic [SEG_IDX_W-1:0] LAST_SEG = SEG_IDX_W'((N_SEG > 0) ? N_SEG - 1 : 0);
    localparam logic [7:0]       LFSR_INIT = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [CNT_W-1:0] HOLD_DEF  = CNT_W'(HOLD_CYC);

    typedef enum logic [1:0] {IDLE, FALL, HOLD, RISE} state_t;

    state_t                 state, state_d;
    logic [7:0]             lfsr;
    logic                   key_d, done_d;
    logic [7:0]             edge_d, edge_inc;
    logic [GLITCH_W-1:0]    seg_cnt, seg_cnt_d, seg_len_m1;
    logic [SEG_IDX_W-1:0]   seg_idx, seg_idx_d;
    logic [CNT_W-1:0]       hold_cnt, hold_cnt_d, hold_init;

    // Segment counters hold L-1 so a segment spans exactly L cycles.
    assign seg_len_m1 = lfsr[GLITCH_W-1:0];
    assign hold_init  = ((hold_len == '0) ? HOLD_DEF : hold_len) - CNT_W'(1);
    assign edge_inc   = (edge_cnt == 8'hFF) ? edge_cnt : edge_cnt + 8'd1;
    assign busy       = (state != IDLE);

    always_comb begin
        // NOTE: every next-value is defaulted first so no branch of the case can infer a latch.
        state_d    = state;
        key_d      = key;
        done_d     = 1'b0;
        edge_d     = edge_cnt;
        seg_cnt_d  = seg_cnt;
        seg_idx_d  = seg_idx;
        hold_cnt_d = hold_cnt;

        unique case (state)
            IDLE: begin
                // The done cycle is already IDLE, so it must refuse a request explicitly.
                if (press_req && !done) begin
                    key_d      = 1'b0;
                    edge_d     = 8'd1;
                    hold_cnt_d = hold_init;
                    seg_cnt_d  = seg_len_m1;
                    seg_idx_d  = '0;
                    state_d    = (N_SEG == 0) ? HOLD : FALL;
                end
            end
            FALL, RISE: begin
                if (seg_cnt == '0) begin
                    key_d     = ~key;
                    edge_d    = edge_inc;
                    seg_cnt_d = seg_len_m1;
                    if (seg_idx == LAST_SEG) begin
                        seg_idx_d = '0;
                        if (state == FALL) begin
                            state_d = HOLD;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        seg_idx_d = seg_idx + SEG_IDX_W'(1);
                    end
                end else begin
                    seg_cnt_d = seg_cnt - GLITCH_W'(1);
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    key_d     = 1'b1;
                    edge_d    = edge_inc;
                    seg_cnt_d = seg_len_m1;
                    seg_idx_d = '0;
                    if (N_SEG == 0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RISE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lfsr     <= LFSR_INIT;
            key      <= 1'b1;
            done     <= 1'b0;
            edge_cnt <= 8'd0;
            seg_cnt  <= '0;
            seg_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_d;
            lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            key      <= key_d;
            done     <= done_d;
            edge_cnt <= edge_d;
            seg_cnt  <= seg_cnt_d;
            seg_idx  <= seg_idx_d;
            hold_cnt <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen: a bouncing and a clean instance checked cycle by
// cycle against a segment-list model of the expected key waveform.
module tb_key_bounce_gen;

    localparam logic [7:0] SEED     = 8'hA5;
    localparam int         HOLD_CYC = 20;
    localparam int         GLITCH_W = 2;
    localparam int         DB_WIN   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        press_b = 1'b0;
    logic        press_c = 1'b0;
    logic [15:0] hold_len = '0;
    logic        key_b, busy_b, done_b;
    logic        key_c, busy_c, done_c;
    logic [7:0]  edge_b, edge_c;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  lfsr_m;
    bit          exp_q[$];
    int          db_cnt;
    logic        db_level;
    int          db_pulses = 0;

    key_bounce_gen #(.N_BOUNCE(3), .GLITCH_W(GLITCH_W), .HOLD_CYC(HOLD_CYC), .CNT_W(16), .SEED(SEED)) u_bounce (
        .clk(clk), .rst(rst), .press_req(press_b), .hold_len(hold_len),
        .key(key_b), .busy(busy_b), .done(done_b), .edge_cnt(edge_b)
    );

    key_bounce_gen #(.N_BOUNCE(0), .GLITCH_W(GLITCH_W), .HOLD_CYC(HOLD_CYC), .CNT_W(16), .SEED(SEED)) u_clean (
        .clk(clk), .rst(rst), .press_req(press_c), .hold_len(hold_len),
        .key(key_c), .busy(busy_c), .done(done_c), .edge_cnt(edge_c)
    );

    always #5 clk = ~clk;

    // Behavioural debouncer: a level change is accepted after DB_WIN stable cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_level <= 1'b1;
            db_cnt   <= 0;
        end else if (key_b != db_level) begin
            if (db_cnt == DB_WIN - 1) begin
                db_level <= key_b;
                db_cnt   <= 0;
                if (!key_b) db_pulses <= db_pulses + 1;
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end else begin
            db_cnt <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_adv(input logic [7:0] s, input int n);
        logic [7:0] v = s;
        for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        lfsr_m = lfsr_adv(lfsr_m, 1);
        #1;
    endtask

    // Expected key level for every cycle from accept+1 up to (not including) the done cycle.
    task automatic build_q(input int nb, input int h, input logic [7:0] v0, output int fall_len);
        logic [7:0] v = v0;
        bit         lvl = 1'b0;
        int         seg_len;
        exp_q.delete();
        for (int s = 0; s < 2 * nb; s++) begin
            seg_len = int'(v & 8'((1 << GLITCH_W) - 1)) + 1;
            repeat (seg_len) exp_q.push_back(lvl);
            v   = lfsr_adv(v, seg_len);
            lvl = ~lvl;
        end
        fall_len = exp_q.size();
        repeat (h) exp_q.push_back(1'b0);
        v   = lfsr_adv(v, h);
        lvl = 1'b1;
        for (int s = 0; s < 2 * nb; s++) begin
            seg_len = int'(v & 8'((1 << GLITCH_W) - 1)) + 1;
            repeat (seg_len) exp_q.push_back(lvl);
            v   = lfsr_adv(v, seg_len);
            lvl = ~lvl;
        end
    endtask

    function automatic logic [10:0] outs(input bit clean);
        return clean ? {key_c, busy_c, done_c, edge_c} : {key_b, busy_b, done_b, edge_b};
    endfunction

    task automatic drive_press(input bit clean, input logic v);
        if (clean) press_c = v;
        else       press_b = v;
    endtask

    task automatic run_press(input bit clean, input logic [15:0] hl, input bit poke);
        int         nb = clean ? 0 : 3;
        int         h  = (hl == 16'd0) ? HOLD_CYC : int'(hl);
        int         fl;
        int         edges = 1;
        bit         prev = 1'b0;
        logic [10:0] o;
        hold_len = hl;
        drive_press(clean, 1'b1);
        build_q(nb, h, lfsr_m, fl);
        tick();
        drive_press(clean, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            hold_len = 16'($urandom);
            if (poke) drive_press(clean, ($urandom_range(0, 3) == 0));
            if (exp_q[i] != prev) edges++;
            prev = exp_q[i];
            o = outs(clean);
            check("key", 32'(o[10]), 32'(exp_q[i]));
            check("busy", 32'(o[9]), 32'd1);
            check("done_early", 32'(o[8]), 32'd0);
            check("edge_cnt_run", 32'(o[7:0]), 32'(edges));
            tick();
        end
        drive_press(clean, poke);
        o = outs(clean);
        check("done_key", 32'(o[10]), 32'd1);
        check("done_busy", 32'(o[9]), 32'd0);
        check("done", 32'(o[8]), 32'd1);
        check("edge_cnt_done", 32'(o[7:0]), 32'(4 * nb + 2));
        tick();
        drive_press(clean, 1'b0);
        o = outs(clean);
        check("after_key", 32'(o[10]), 32'd1);
        check("after_busy", 32'(o[9]), 32'd0);
        check("after_done", 32'(o[8]), 32'd0);
        check("after_edge_cnt", 32'(o[7:0]), 32'(4 * nb + 2));
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        lfsr_m = SEED;
        tick();
    endtask

    initial begin
        int fl;
        int p0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_key", 32'(key_b), 32'd1);
        check("rst_busy", 32'(busy_b), 32'd0);
        check("rst_done", 32'(done_b), 32'd0);
        check("rst_edge_cnt", 32'(edge_b), 32'd0);
        check("rst_key_clean", 32'(key_c), 32'd1);
        rst    = 1'b1;
        lfsr_m = SEED;
        repeat (2) tick();

        // Clean instance: explicit and default hold lengths.
        run_press(1'b1, 16'd5, 1'b0);
        repeat (3) tick();
        run_press(1'b1, 16'd0, 1'b1);
        repeat (2) tick();

        // Bouncing instance: nominal, default hold with ignored requests, random mix.
        run_press(1'b0, 16'd20, 1'b0);
        repeat (4) tick();
        run_press(1'b0, 16'd0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 9)) tick();
            run_press(1'b0, 16'($urandom_range(0, 30)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset landing in the middle of HOLD.
        repeat (3) tick();
        hold_len = 16'd20;
        press_b  = 1'b1;
        build_q(3, 20, lfsr_m, fl);
        tick();
        press_b = 1'b0;
        repeat (fl + 5) tick();
        check("midhold_busy", 32'(busy_b), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_key", 32'(key_b), 32'd1);
        check("async_busy", 32'(busy_b), 32'd0);
        check("async_done", 32'(done_b), 32'd0);
        check("async_edge_cnt", 32'(edge_b), 32'd0);
        #2 rst = 1'b1;
        lfsr_m = SEED;
        tick();
        check("post_rst_busy", 32'(busy_b), 32'd0);
        check("post_rst_key", 32'(key_b), 32'd1);
        run_press(1'b0, 16'd6, 1'b0);

        // Same press at the same offset after reset, twice.
        for (int r = 0; r < 2; r++) begin
            pulse_reset();
            repeat (3) tick();
            run_press(1'b0, 16'd20, 1'b0);
        end

        // Ten presses into the debouncer, each with enough idle time to register release.
        repeat (DB_WIN + 4) tick();
        p0 = db_pulses;
        for (int k = 0; k < 10; k++) begin
            run_press(1'b0, 16'($urandom_range(10, 40)), 1'($urandom_range(0, 1)));
            repeat (DB_WIN + 4) tick();
        end
        check("debounce_pulses", 32'(db_pulses - p0), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
